// File: rtl/laplace_pkg.sv
// Shared types and constants for the streaming 3x3 Laplacian controller.
// The window is indexed [row][col], with row 0 oldest and col 0 oldest.
package laplace_pkg;

   localparam int unsigned PIX_W = 8;
   localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;
   localparam int unsigned WIN_N = 9;

   // Byte positions inside the packed window (k = 3*row + col)
   localparam int unsigned UP     = 1;
   localparam int unsigned LEFT   = 3;
   localparam int unsigned CENTER = 4;
   localparam int unsigned RIGHT  = 5;
   localparam int unsigned DOWN   = 7;

   typedef logic [PIX_W-1:0] pix_t;
   typedef pix_t [2:0] win_row_t;
   // Packed so that flattening places window[r][c] at byte 3r+c
   typedef win_row_t [2:0] win_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/arit.sv
// 4-neighbour Laplacian on a packed 3x3 window: 4*centre - up - left - right - down.
// Reports the raw low byte plus underflow (<0) and overflow (>255) flags.
module arit
   import laplace_pkg::*;
(
   input  logic [WIN_N*PIX_W-1:0] in_pixels,
   output logic [PIX_W-1:0]       result,
   output logic                   underflow,
   output logic                   overflow
);

   // Range is -1020..1020, so three extra bits hold it in two's complement
   localparam int unsigned ACC_W = PIX_W + 3;

   logic [ACC_W-1:0] acc;

   // Kernel weights: +4 at the centre, -1 at the four neighbours, 0 at corners
   always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < WIN_N; k++) begin
         case (k)
            CENTER:                 acc = acc + (ACC_W'(in_pixels[k*PIX_W +: PIX_W]) << 2);
            UP, LEFT, RIGHT, DOWN:  acc = acc - ACC_W'(in_pixels[k*PIX_W +: PIX_W]);
            default:                acc = acc;
         endcase
      end
   end

   assign underflow = acc[ACC_W-1];
   assign overflow  = !acc[ACC_W-1] && (acc[ACC_W-2:PIX_W] != '0);
   assign result    = acc[PIX_W-1:0];

endmodule

// File: rtl/laplace_row_buf.sv
// Two row-history buffers sharing one column port; row1 holds two rows back, row0 one row back.
// Reads are combinational at col; a write shifts row0 into row1 and stores the new pixel in row0.
module laplace_row_buf
   import laplace_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned COL_W = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [COL_W-1:0] col,
   input  pix_t             din,
   output pix_t             rd_top_c,
   output pix_t             rd_mid_c
);

   pix_t row0 [IMG_W];
   pix_t row1 [IMG_W];

   assign rd_top_c = row1[col];
   assign rd_mid_c = row0[col];

   // Contents are not reset; every entry is written before the window reads it
   always_ff @(posedge clk) begin
      if (wr_en) begin
         row1[col] <= row0[col];
         row0[col] <= din;
      end
   end

endmodule

// File: rtl/laplace_stream_ctrl.sv
// Frame sequencer: builds a sliding 3x3 window over a raster pixel stream, runs the
// Laplacian on each complete window and emits saturated results on a valid/ready port.
module laplace_stream_ctrl
   import laplace_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned COL_W = $clog2(IMG_W),
   parameter int unsigned ROW_W = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_clip,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   win_t             win_q, win_d;
   pix_t             rd_top, rd_mid;
   pix_t             lap_result;
   logic             lap_under, lap_over;
   logic             xfer, col_last, row_last, qualify, load, done_set;

   assign in_ready = ((state_q == PRIME) || (state_q == RUN)) && (!out_valid || out_ready);
   assign xfer     = in_valid && in_ready;
   assign col_last = (col_q == COL_W'(IMG_W - 1));
   assign row_last = (row_q == ROW_W'(IMG_H - 1));
   assign qualify  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
   assign load     = xfer && qualify;
   assign busy     = (state_q != IDLE);

   laplace_row_buf #(
      .IMG_W (IMG_W),
      .COL_W (COL_W)
   ) u_row_buf (
      .clk      (clk),
      .wr_en    (xfer),
      .col      (col_q),
      .din      (in_pixel),
      .rd_top_c (rd_top),
      .rd_mid_c (rd_mid)
   );

   // Window as it will be after the current pixel; arit sees the completed window
   always_comb begin
      win_d = win_q;
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = win_q[r][1];
         win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd_top;
      win_d[1][2] = rd_mid;
      win_d[2][2] = in_pixel;
   end

   arit u_arit (
      .in_pixels (win_d),
      .result    (lap_result),
      .underflow (lap_under),
      .overflow  (lap_over)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // start while done is still high is dropped, not queued
   always_comb begin
      state_d  = state_q;
      done_set = 1'b0;
      case (state_q)
         IDLE:  if (start && !done) state_d = PRIME;
         PRIME: if (xfer && (row_q == ROW_W'(2)) && (col_q == COL_W'(1))) state_d = RUN;
         RUN:   if (xfer && col_last && row_last) state_d = DRAIN;
         DRAIN: begin
            if (out_valid && out_ready) begin
               state_d  = IDLE;
               done_set = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         col_q <= '0;
         row_q <= '0;
         win_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         col_q <= '0;
         row_q <= '0;
      end else if (xfer) begin
         win_q <= win_d;
         if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_q <= col_q + COL_W'(1);
         end
      end
   end

   // Output register: a new load beats a same-cycle accept; underflow wins over overflow
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_clip  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= done_set;
         if (load) begin
            out_valid <= 1'b1;
            if (lap_under) begin
               out_pixel <= '0;
               out_clip  <= 1'b1;
            end else if (lap_over) begin
               out_pixel <= PIX_MAX;
               out_clip  <= 1'b1;
            end else begin
               out_pixel <= lap_result;
               out_clip  <= 1'b0;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_laplace_stream_ctrl.sv
// Scoreboard bench for laplace_stream_ctrl on a 5x4 frame: expected results are queued as
// qualifying pixels are driven and compared as the DUT hands them off.
module tb_laplace_stream_ctrl;

   localparam int W    = 5;
   localparam int H    = 4;
   localparam int NOUT = (W - 2) * (H - 2);

   logic       clk = 1'b0;
   logic       n_rst, start, in_valid, in_ready, out_valid, out_ready, out_clip, busy, done;
   logic [7:0] in_pixel, out_pixel;

   always #5 clk = ~clk;

   laplace_stream_ctrl #(
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .in_pixel  (in_pixel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_pixel (out_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_clip  (out_clip),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic [7:0] pix;
      logic       clip;
   } exp_t;

   int         checks   = 0;
   int         failures = 0;
   int         img [H][W];
   exp_t       sb [$];
   int         out_n    = 0;
   int         done_cnt = 0;
   int         cyc      = 0;
   int         last_acc = -10;
   logic [7:0] log_pix  [16];
   logic       log_clip [16];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference Laplacian for the window completed by pixel (x, y)
   function automatic exp_t model(input int x, input int y);
      exp_t r;
      int   cx, cy, v;
      cx = x - 1;
      cy = y - 1;
      v  = 4 * img[cy][cx] - img[cy-1][cx] - img[cy][cx-1] - img[cy][cx+1] - img[cy+1][cx];
      if (v < 0) begin
         r.pix = 8'd0;   r.clip = 1'b1;
      end else if (v > 255) begin
         r.pix = 8'd255; r.clip = 1'b1;
      end else begin
         r.pix = 8'(v);  r.clip = 1'b0;
      end
      return r;
   endfunction

   // Output monitor: pops the scoreboard on each handshake and times the done pulse
   always @(negedge clk) begin
      exp_t e;
      if (n_rst) begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_extra: got pix=%0d clip=%0b, expected no output", out_pixel, out_clip);
            end else begin
               e = sb.pop_front();
               if (out_pixel !== e.pix || out_clip !== e.clip) begin
                  failures++;
                  $display("FAIL sb_out[%0d]: got pix=%0d clip=%0b, expected pix=%0d clip=%0b",
                           out_n, out_pixel, out_clip, e.pix, e.clip);
               end
            end
            if (out_n < 16) begin
               log_pix[out_n]  = out_pixel;
               log_clip[out_n] = out_clip;
            end
            out_n++;
            last_acc = cyc;
         end
         if (done) begin
            done_cnt++;
            checks++;
            if (cyc !== last_acc + 1) begin
               failures++;
               $display("FAIL done_timing: done at cycle %0d, expected cycle %0d", cyc, last_acc + 1);
            end
         end
      end
   end

   task automatic fill(input int v);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = v;
   endtask

   task automatic fill_random();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = int'($urandom_range(0, 255));
   endtask

   task automatic new_frame();
      sb.delete();
      out_n    = 0;
      done_cnt = 0;
   endtask

   task automatic drive_frame(input int npix, input bit gaps);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int p = 0; p < npix; p++) begin
         int x, y, wc;
         x  = p % W;
         y  = p / W;
         wc = 0;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_pixel = 8'(img[y][x]);
         in_valid = 1'b1;
         @(negedge clk);
         while (!in_ready && wc < 200) begin
            wc++;
            @(negedge clk);
         end
         if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: pixel %0d in_ready=%0b, expected 1", p, in_ready);
            in_valid = 1'b0;
            return;
         end
         if (x >= 2 && y >= 2) sb.push_back(model(x, y));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_frame(input string tag);
      int wc;
      wc = 0;
      while (done_cnt == 0 && wc < 100) begin
         @(negedge clk);
         wc++;
      end
      checks++;
      if (done_cnt == 0) begin
         failures++;
         $display("FAIL %s_done_timeout: done_cnt=%0d, expected 1", tag, done_cnt);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (out_n !== NOUT) begin
         failures++;
         $display("FAIL %s_out_count: got %0d, expected %0d", tag, out_n, NOUT);
      end
      checks++;
      if (done_cnt !== 1) begin
         failures++;
         $display("FAIL %s_done_count: got %0d, expected 1", tag, done_cnt);
      end
      checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL %s_idle: busy=%0b pending=%0d, expected busy=0 pending=0", tag, busy, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_clip !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: valid=%0b pix=%0d clip=%0b, expected 0/0/0", out_valid, out_pixel, out_clip);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy=%0b done=%0b in_ready=%0b, expected 0/0/0", busy, done, in_ready);
      end
      @(posedge clk); #1 n_rst = 1'b1;
   endtask

   task automatic test_flat();
      fill(100);
      new_frame();
      drive_frame(W * H, 1'b0);
      finish_frame("flat");
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (log_pix[i] !== 8'd0 || log_clip[i] !== 1'b0) begin
            failures++;
            $display("FAIL flat_val[%0d]: got pix=%0d clip=%0b, expected 0/0", i, log_pix[i], log_clip[i]);
         end
      end
   endtask

   task automatic test_peak();
      fill(0);
      img[1][2] = 70;
      img[0][2] = 10; img[1][1] = 10; img[1][3] = 10; img[2][2] = 10;
      new_frame();
      drive_frame(W * H, 1'b0);
      finish_frame("peak");
      checks++;
      if (log_pix[1] !== 8'd240 || log_clip[1] !== 1'b0) begin
         failures++;
         $display("FAIL peak_centre: got pix=%0d clip=%0b, expected 240/0", log_pix[1], log_clip[1]);
      end
   endtask

   task automatic test_sat();
      fill(0);
      img[1][2] = 255;
      new_frame();
      drive_frame(W * H, 1'b0);
      finish_frame("sat");
      checks++;
      if (log_pix[1] !== 8'd255 || log_clip[1] !== 1'b1) begin
         failures++;
         $display("FAIL sat_over: got pix=%0d clip=%0b, expected 255/1", log_pix[1], log_clip[1]);
      end
      checks++;
      if (log_pix[0] !== 8'd0 || log_clip[0] !== 1'b1 || log_pix[2] !== 8'd0 || log_clip[2] !== 1'b1) begin
         failures++;
         $display("FAIL sat_under: got %0d/%0b and %0d/%0b, expected 0/1 and 0/1",
                  log_pix[0], log_clip[0], log_pix[2], log_clip[2]);
      end
   endtask

   task automatic test_neg();
      fill(0);
      img[1][2] = 10;
      img[0][2] = 20; img[1][1] = 20; img[1][3] = 20; img[2][2] = 20;
      new_frame();
      drive_frame(W * H, 1'b1);
      finish_frame("neg");
      checks++;
      if (log_pix[1] !== 8'd0 || log_clip[1] !== 1'b1) begin
         failures++;
         $display("FAIL neg_centre: got pix=%0d clip=%0b, expected 0/1", log_pix[1], log_clip[1]);
      end
   endtask

   task automatic stall_output();
      int         wc;
      logic [7:0] held;
      wc = 0;
      do begin
         @(negedge clk); #1;
         wc++;
      end while (out_n < 2 && wc < 200);
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      held = out_pixel;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL bp_hold_valid: out_valid=%0b busy=%0b, expected 1/1", out_valid, busy);
      end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_pixel !== held) begin
            failures++;
            $display("FAIL bp_stall[%0d]: in_ready=%0b pix=%0d, expected 0 and pix=%0d", i, in_ready, out_pixel, held);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
   endtask

   task automatic test_backpressure();
      fill_random();
      new_frame();
      fork
         drive_frame(W * H, 1'b0);
         stall_output();
      join
      finish_frame("bp");
   endtask

   task automatic test_reset_abort();
      fill_random();
      new_frame();
      drive_frame(14, 1'b0);
      n_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset: valid=%0b in_ready=%0b busy=%0b done=%0b, expected all 0",
                  out_valid, in_ready, busy, done);
      end
      new_frame();
      @(posedge clk); #1 n_rst = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (done_cnt !== 0 || out_n !== 0) begin
         failures++;
         $display("FAIL abort_quiet: done_cnt=%0d outputs=%0d, expected 0/0", done_cnt, out_n);
      end
      fill(100);
      new_frame();
      drive_frame(W * H, 1'b0);
      finish_frame("refresh");
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (log_pix[i] !== 8'd0 || log_clip[i] !== 1'b0) begin
            failures++;
            $display("FAIL refresh_val[%0d]: got pix=%0d clip=%0b, expected 0/0", i, log_pix[i], log_clip[i]);
         end
      end
   endtask

   initial begin
      n_rst     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_pixel  = 8'd0;
      out_ready = 1'b1;
      test_reset();
      test_flat();
      test_peak();
      test_sat();
      test_neg();
      test_backpressure();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/laplace_stream_ctrl.md
Name: laplace_stream_ctrl

Overview:
Streams a raster image one pixel per transfer and builds a sliding 3x3 window from two row buffers. Each complete window goes to the existing 4-neighbour Laplacian arithmetic block (instantiated as arit). The signed result is saturated to 8 bits and emitted on a valid/ready output stream. The block sits between the PCIe/Avalon pixel source and the result FIFO, and sequences one frame per start pulse.

Parameters:
IMG_W, 640, pixels per row (min 3)
IMG_H, 480, rows per frame (min 3)
COL_W, $clog2(IMG_W), column counter width
ROW_W, $clog2(IMG_H), row counter width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when in IDLE
in_pixel  in  8  input pixel, raster order
in_valid  in  1  input pixel present
in_ready  out  1  controller accepts in_pixel this cycle
out_pixel  out  8  saturated Laplacian result
out_valid  out  1  out_pixel holds a result
out_ready  in  1  downstream accepts out_pixel
out_clip  out  1  qualifies out_pixel; result was saturated
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last output of a frame is accepted

Behaviour:
- Reset (asynchronous, n_rst=0): state=IDLE. col=0, row=0. Window registers=0. Outputs: out_valid=0, out_pixel=0, out_clip=0, done=0, busy=0, in_ready=0.
- Row-buffer RAM contents are not reset; every entry is rewritten before it is read.
- States:
  - IDLE: start -> PRIME. start is ignored in every other state.
  - PRIME: accepting rows 0-1 plus columns 0-1 of row 2. No outputs are produced.
  - RUN: window valid when row>=2 and col>=2. Each such accepted pixel produces one output.
  - DRAIN: entered after pixel (IMG_W-1, IMG_H-1) is accepted. Waits for the final output handshake, then pulses done and goes to IDLE.
- busy=1 in PRIME, RUN and DRAIN.
- Input handshake:
  - in_ready = (state is PRIME or RUN) and (!out_valid or out_ready).
  - A transfer occurs when in_valid and in_ready are both 1.
- On each transfer:
  - The window shifts left by one column. The new right column is {rowbuf1[col], rowbuf0[col], in_pixel}, top to bottom.
  - rowbuf1[col] <= rowbuf0[col], then rowbuf0[col] <= in_pixel.
  - col increments. When col reaches IMG_W-1 it wraps to 0 and row increments.
- Window packing to arit.in_pixels: byte k = window[r][c] with k = 3r+c. Row 0 is the oldest row, column 0 the oldest column, so byte 4 is the centre.
- The window column shift uses the updated window, so arit sees the window completed by the current pixel. No invalid window is ever presented as valid across a row wrap; the first two columns of each row are suppressed.
- Output register:
  - Loaded the cycle after a qualifying transfer, so latency is 1 clk.
  - If the arit underflow flag is set: out_pixel=0, out_clip=1.
  - Else if the overflow flag is set: out_pixel=255, out_clip=1.
  - Else out_pixel = arit result, out_clip=0. Underflow has priority.
- out_valid/out_pixel/out_clip hold stable while out_valid=1 and out_ready=0.
- out_valid clears on acceptance unless a new result loads the same cycle (back-to-back throughput: 1 pixel/clk).
- Output count per frame is exactly (IMG_W-2)*(IMG_H-2).
- Simultaneous events:
  - An output accept and a new load in the same cycle: the load wins and out_valid stays 1.
  - done asserts on the cycle after the final accept.
  - start coinciding with done is ignored; it is not queued.
- Reset mid-frame aborts the frame. No done pulse is generated.

Decomposition:
- Package laplace_pkg holds:
  - state_t enum (IDLE, PRIME, RUN, DRAIN)
  - PIX_W=8
  - PIX_MAX=8'hFF
  - window index constants (CENTER=4, UP=1, LEFT=3, RIGHT=5, DOWN=7)
- One natural sub-module: laplace_row_buf. It holds the two IMG_W x 8 row buffers with a single read/shift port indexed by col, and is inferable as simple dual-port RAM.
- arit is instantiated unchanged.

Test Plan:
- IMG_W=5, IMG_H=4, all pixels 100, out_ready=1 -> exactly 6 outputs, all 0 with out_clip=0; done pulses once, one cycle after the 6th accept; busy then drops.
- 5x4 frame, zeros except (2,1)=70 with its 4 neighbours=10 -> output for centre (2,1) = 240, out_clip=0.
- 5x4 frame, zeros except (2,1)=255 -> centre output 255 with out_clip=1. Neighbouring windows (1,1) and (3,1) give 0 with out_clip=1 (underflow).
- Centre 10 with neighbours 20 (40-80=-40) -> out_pixel=0, out_clip=1.
- Backpressure: hold out_ready=0 for 10 cycles mid-RUN -> in_ready=0 throughout and out_pixel stays stable. On release, the stream resumes with no lost or duplicated outputs; the frame total still equals 6.
- Assert n_rst=0 mid-RUN, then start a fresh all-100 frame -> no done for the aborted frame. The new frame yields 6 zero outputs; the stale window causes no spurious outputs.
